// File: rtl/ram_sp_pkg.sv
// Shared types for the single-port RAM command sequencer: FSM states, the queued
// command record and the command buffer depth.
package ram_sp_pkg;

    localparam int CMD_BUF_DEPTH = 2;
    localparam int CMD_ADDR_W    = 8;
    localparam int CMD_DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

    // Field widths track the controller's ADDR_WIDTH/DATA_WIDTH defaults.
    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_sp_cmd_fifo.sv
// Two-entry synchronous command FIFO placed in front of the RAM sequencer FSM.
// Pushes are dropped when full and pops are ignored when empty.
module ram_sp_cmd_fifo
    import ram_sp_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t push_cmd_i,
    input  logic pop_i,
    output cmd_t pop_cmd_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(CMD_BUF_DEPTH);

    cmd_t             mem_q [CMD_BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == (PTR_W+1)'(CMD_BUF_DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_cmd_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries data only, so it stays out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_cmd_i;
    end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Command sequencer for a single-port sync RAM with a shared bidirectional data bus.
// Define RAM_SP_CTRL_CMD_BUF_EN to put a 2-entry command FIFO in front of the FSM.
module ram_sp_ctrl
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                  state_q;
    logic                    ram_cs_q;
    logic                    ram_we_q;
    logic                    ram_oe_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_hs;
    logic                    bus_drive;
    logic                    take;
    cmd_t                    in_cmd;
    cmd_t                    head_cmd;

    assign in_cmd = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    assign rsp_hs = rsp_valid_q && rsp_ready;

`ifdef RAM_SP_CTRL_CMD_BUF_EN
    logic fifo_full;
    logic fifo_empty;
    logic pop_ok;

    // A read waits until the pending response is gone or leaves this cycle.
    assign cmd_ready = !fifo_full;
    assign pop_ok    = head_cmd.we || !rsp_valid_q || rsp_ready;
    assign take      = (state_q == IDLE) && !fifo_empty && pop_ok;

    ram_sp_cmd_fifo u_cmd_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (cmd_valid),
        .push_cmd_i (in_cmd),
        .pop_i      (take),
        .pop_cmd_o  (head_cmd),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );
`else
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
    assign take      = cmd_valid && cmd_ready;
    assign head_cmd  = in_cmd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (rsp_hs) rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        ram_cs_q   <= 1'b1;
                        ram_addr_q <= head_cmd.addr;
                        wdata_q    <= head_cmd.wdata;
                        if (head_cmd.we) begin
                            ram_we_q <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            ram_oe_q <= 1'b1;
                            state_q  <= RD_ADDR;
                        end
                    end
                end
                WRITE: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
                RD_ADDR: state_q <= RD_DATA;
                RD_DATA: begin
                    rsp_rdata_q <= ram_data;
                    rsp_valid_q <= 1'b1;
                    ram_cs_q    <= 1'b0;
                    ram_oe_q    <= 1'b0;
                    state_q     <= TURN;
                end
                // Dead cycle so the RAM has released the bus before we can drive it.
                TURN:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_drive = (state_q == WRITE);
    assign ram_data  = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_addr  = ram_addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    a_no_contention: assert property (@(posedge clk) disable iff (rst) !(bus_drive && ram_oe_q));

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Randomized and directed bench for ram_sp_ctrl attached to a behavioural sync RAM,
// checked every cycle against an in-order command/response reference model.
module tb_ram_sp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ram_clr = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic [7:0] ram_addr;
    wire  [7:0] ram_data;
    logic       ram_cs, ram_we, ram_oe;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_sp_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    // Behavioural single-port sync RAM: captures on the address cycle, drives while cs&&oe.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_dout = '0;
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : 8'bz;
    always @(posedge clk) begin
        if (ram_clr) for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
        if (ram_cs && ram_oe && !ram_we) ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: committed memory plus accepted-but-not-landed writes, in order.
    typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;
    wr_t        wq[$];
    logic [7:0] rq[$];
    int         riseq[$];
    logic [7:0] mem_m [256];
    int  cyc = 0, free_cyc = 0, last_ramdrv = -100, min_gap = 1000, we_cnt = 0;
    bit  pend_m = 0, prev_hold = 0, prev_rst = 0;
    logic [7:0] last_rdata = '0;

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        logic [7:0] v;
        v = mem_m[a];
        foreach (wq[i]) if (wq[i].addr == a) v = wq[i].data;
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            if (ram_clr) for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
            if (ram_cs && ram_we) mem_m[ram_addr] = ram_data;
            if (prev_rst)
                chk("reset_state", {ram_cs, ram_we, ram_oe, rsp_valid, ram_addr, rsp_rdata}, 32'h0);
            wq.delete(); rq.delete(); riseq.delete();
            pend_m = 0; prev_hold = 0; free_cyc = cyc + 1; last_ramdrv = -100;
            prev_rst = 1;
        end else begin
            bit exp_rdy, ctrl_drv, ram_drv;
            prev_rst = 0;
`ifndef RAM_SP_CTRL_CMD_BUF_EN
            if (riseq.size() != 0 && riseq[0] == cyc) begin
                void'(riseq.pop_front());
                pend_m = 1;
            end
            chk("rsp_valid", rsp_valid, pend_m);
            exp_rdy = (cyc >= free_cyc) && !pend_m;
            chk("cmd_ready", cmd_ready, exp_rdy);
            chk("ram_we_timing", ram_cs && ram_we, wq.size() != 0 && wq[0].cyc == cyc);
`endif
            if (rsp_valid) begin
                if (prev_hold) chk("rsp_hold", rsp_rdata, last_rdata);
                if (rsp_ready) begin
                    if (rq.size() != 0) chk("rsp_data", rsp_rdata, rq.pop_front());
                    else chk("rsp_extra", 1, 0);
                    pend_m = 0;
                end
                prev_hold = !rsp_ready;
                last_rdata = rsp_rdata;
            end else prev_hold = 0;
            if (ram_cs && ram_we) begin
                we_cnt++;
                if (wq.size() != 0) begin
                    chk("ram_wr_addr", ram_addr, wq[0].addr);
                    chk("ram_wr_data", ram_data, wq[0].data);
                    mem_m[wq[0].addr] = wq[0].data;
                    void'(wq.pop_front());
                end else chk("ram_write_extra", 1, 0);
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_we) begin
                    wq.push_back('{addr: cmd_addr, data: cmd_wdata, cyc: cyc + 1});
                    free_cyc = cyc + 2;
                end else begin
                    rq.push_back(exp_read(cmd_addr));
                    riseq.push_back(cyc + 3);
                    free_cyc = cyc + 4;
                end
            end
            ctrl_drv = ram_cs && ram_we;
            ram_drv  = ram_cs && ram_oe;
            chk("bus_contention", ctrl_drv && ram_drv, 0);
            if (ctrl_drv) begin
                if (cyc - last_ramdrv < min_gap) min_gap = cyc - last_ramdrv;
                chk("turnaround_gap", (cyc - last_ramdrv) > 1, 1);
            end
            if (ram_drv) last_ramdrv = cyc;
        end
    end

    task automatic send(input bit we, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [7:0] exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                chk(name, rsp_rdata, exp);
                @(posedge clk); #1;
                return;
            end
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int w0;
        logic [7:0] a;
        // 1: reset with a command offered
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_we_oe", {ram_cs, ram_we, ram_oe}, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; ram_clr = 1'b0; rst = 1'b0;
        chk("rst_no_ram_write", ram_mem[8'h55], 8'h00);

        // 2: write then read
        w0 = we_cnt;
        send(1'b1, 8'h12, 8'hA5);
        send(1'b0, 8'h12, 8'h00);
        get_rsp("wr_rd_0x12", 8'hA5);
        chk("we_single_pulse", we_cnt - w0, 1);

        // 3: response backpressure
        rsp_ready = 1'b0;
        send(1'b0, 8'h12, 8'h00);
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        @(posedge clk); #1;
`ifndef RAM_SP_CTRL_CMD_BUF_EN
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h12;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_rdata, 8'hA5);
            chk("bp_no_ram_cycle", ram_cs, 0);
`ifndef RAM_SP_CTRL_CMD_BUF_EN
            chk("bp_cmd_ready", cmd_ready, 0);
`endif
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        send(1'b0, 8'h12, 8'h00);
        get_rsp("bp_reread", 8'hA5);

        // 4: read immediately followed by a write, then read it back
        min_gap = 1000;
        send(1'b0, 8'h00, 8'h00);
        send(1'b1, 8'h01, 8'h3C);
        send(1'b0, 8'h01, 8'h00);
        get_rsp("turn_rd_0x01", 8'h3C);
        chk("turn_dead_cycle", min_gap >= 2, 1);

        // 5: address extremes
        send(1'b1, 8'h00, 8'h11);
        send(1'b1, 8'hFF, 8'hEE);
        send(1'b0, 8'h00, 8'h00);
        get_rsp("addr_0x00", 8'h11);
        send(1'b0, 8'hFF, 8'h00);
        get_rsp("addr_0xFF", 8'hEE);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_we    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0: a = 8'h00;
                1: a = 8'hFF;
                2: a = 8'h12;
                3: a = 8'h01;
                default: a = 8'($urandom_range(0, 255));
            endcase
            cmd_addr  = a;
            cmd_wdata = 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

`ifdef RAM_SP_CTRL_CMD_BUF_EN
        // 6: buffered writes while a response is pending, then a mid-stream reset
        begin
            bit saw_full;
            int n;
            saw_full = 0; n = 0;
            rsp_ready = 1'b0;
            send(1'b0, 8'h12, 8'h00);
            for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_we = 1'b1;
            for (int g = 0; g < 100 && n < 5; g++) begin
                cmd_addr = 8'h20 + 8'(n); cmd_wdata = 8'h50 + 8'(n);
                @(negedge clk);
                if (cmd_ready) n++; else saw_full = 1'b1;
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            chk("buf_all_accepted", n, 5);
            chk("buf_full_seen", saw_full, 1);
            rsp_ready = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            send(1'b0, 8'h24, 8'h00);
            get_rsp("buf_rd_0x24", 8'h54);
            send(1'b0, 8'h20, 8'h00);
            get_rsp("buf_rd_0x20", 8'h50);
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h61;
            @(posedge clk); #1;
            cmd_addr = 8'h31; cmd_wdata = 8'h62;
            @(posedge clk); #1;
            cmd_valid = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("buf_rst_ready", cmd_ready, 1);
            chk("buf_rst_idle", ram_cs, 0);
            repeat (10) @(posedge clk);
            #1;
            send(1'b0, 8'h30, 8'h00);
            get_rsp("buf_rst_landed", 8'h61);
            send(1'b0, 8'h31, 8'h00);
            repeat (10) @(posedge clk);
            #1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
